// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: opcodes and controller states.
package alu_pkg;

    // Operation select codes presented on the op port
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // ADD and SUB ripple a carry through the adder cell; the logic ops do not
    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder: the one arithmetic cell reused for every bit position.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the parity of the three inputs, carry is their majority
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one operand bit per clock, LSB first, through a single
// full-adder cell with a registered carry. Start/busy/done handshake.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [1:0]       op_q;
    logic             carry;

    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_cout;
    logic             bit_s;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;

    // A new request is taken whenever the datapath is not mid-operation,
    // which includes the DONE cycle so operations can run back-to-back.
    assign accept   = start && (state != S_RUN);
    assign last_bit = (state == S_RUN) && (cnt == LAST_CNT);
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Select this cycle's result bit and carry update from the latched opcode
    always_comb begin
        bit_s      = 1'b0;
        carry_next = carry;
        case (op_q)
            OP_ADD, OP_SUB: begin
                bit_s      = fa_s;
                carry_next = fa_cout;
            end
            OP_AND:  bit_s = a_sr[0] & b_sr[0];
            OP_XOR:  bit_s = a_sr[0] ^ b_sr[0];
            default: bit_s = 1'b0;
        endcase
        // Result bits enter at the MSB so the LSB ends up at bit 0 after WIDTH shifts
        res_next = {bit_s, res_sr[WIDTH-1:1]};
    end

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Controller next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = start ? S_RUN : S_IDLE;
            S_RUN:   state_next = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand/result shift registers, carry, bit counter and published outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            op_q   <= OP_ADD;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert B here and seed the carry with 1
            a_sr  <= a;
            b_sr  <= (op == OP_SUB) ? ~b : b;
            op_q  <= op;
            carry <= (op == OP_SUB);
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            carry  <= carry_next;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                // Outputs move only here, so they hold steady between done pulses
                result <= res_next;
                cout   <= is_arith(op_q) ? fa_cout : 1'b0;
                zero   <= (res_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu: behavioural reference model with a
// per-cycle compare process, plus directed operations with literal expectations.
module tb_bit_serial_alu;

    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    bit_serial_alu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: {cout, result} of an operation computed with plain arithmetic
    function automatic logic [WIDTH:0] model_op(input logic [1:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        case (o)
            OP_ADD: return {1'b0, x} + {1'b0, y};
            OP_SUB: begin
                d = x - y;
                return {(x >= y), d};
            end
            OP_AND: return {1'b0, x & y};
            default: return {1'b0, x ^ y};
        endcase
    endfunction

    // Model: an accepted request completes WIDTH edges later; outputs update then
    int               remaining = 0;
    logic [WIDTH:0]   pending   = '0;
    logic             m_done    = 1'b0;
    logic [WIDTH-1:0] m_result  = '0;
    logic             m_cout    = 1'b0;
    logic             m_zero    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining = 0;
            m_done    = 1'b0;
            m_result  = '0;
            m_cout    = 1'b0;
            m_zero    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    m_done   = 1'b1;
                    m_cout   = pending[WIDTH];
                    m_result = pending[WIDTH-1:0];
                    m_zero   = (pending[WIDTH-1:0] == '0);
                end
            end else if (start) begin
                pending   = model_op(op, a, b);
                remaining = WIDTH;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("busy",   32'(busy),   32'(remaining > 0));
            chk("done",   32'(done),   32'(m_done));
            chk("result", 32'(result), 32'(m_result));
            chk("cout",   32'(cout),   32'(m_cout));
            chk("zero",   32'(zero),   32'(m_zero));
        end
    end

    // One operation with literal expectations. sync=0 issues start at the
    // current negedge (used from a DONE cycle); inject pulses start mid-run.
    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic [WIDTH-1:0] er, input logic ec, input logic ez,
                          input bit sync, input bit inject);
        int n;
        int busy_cnt;
        logic [WIDTH-1:0] prev;
        if (sync) @(negedge clk);
        prev  = result;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(3));
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
        busy_cnt = busy ? 1 : 0;
        n = 0;
        while (!done && n < WIDTH + 4) begin
            chk({name, "_result_held"}, 32'(result), 32'(prev));
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            if (inject && n == 3) begin
                start = 1'b1;
                a     = 8'h01;
                b     = 8'h01;
                op    = OP_ADD;
            end
            if (inject && n == 5) start = 1'b0;
        end
        chk({name, "_latency"},  32'(n),        32'(WIDTH));
        chk({name, "_busy_cyc"}, 32'(busy_cnt), 32'(WIDTH));
        chk({name, "_result"},   32'(result),   32'(er));
        chk({name, "_cout"},     32'(cout),     32'(ec));
        chk({name, "_zero"},     32'(zero),     32'(ez));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = OP_ADD;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout",   32'(cout),   32'd0);
        chk("rst_zero",   32'(zero),   32'd0);
        rst      = 1'b0;
        checking = 1'b1;

        // Model pins: literal answers the reference must reproduce
        chk("model_add", 32'(model_op(OP_ADD, 8'h5A, 8'h3C)), 32'h096);
        chk("model_sub", 32'(model_op(OP_SUB, 8'h10, 8'h20)), 32'h0F0);
        chk("model_eq",  32'(model_op(OP_SUB, 8'h20, 8'h20)), 32'h100);

        run_op("add1", OP_ADD, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("add2", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op("sub1", OP_SUB, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("sub2", OP_SUB, 8'h20, 8'h20, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op("and1", OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("xor1", OP_XOR, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("ignore", OP_ADD, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 1'b1, 1'b1);
        // Start issued in the DONE cycle of the previous operation
        run_op("b2b", OP_XOR, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges during RUN
        @(negedge clk);
        start = 1'b1;
        op    = OP_ADD;
        a     = 8'h5A;
        b     = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",   32'(busy),   32'd0);
        chk("arst_done",   32'(done),   32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_cout",   32'(cout),   32'd0);
        chk("arst_zero",   32'(zero),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            chk("arst_no_done", 32'(done), 32'd0);
        end
        run_op("post_rst", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop if the run ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
